// File: rtl/led_display_row_driver_pkg.sv
// Shared types for the LED panel row path: the row bundle handed from
// the frame source to the panel driver, the HUB75 pin bundle and sizes.
package led_display_row_driver_pkg;

   localparam int GL_NUM_COL_PIXELS = 32;
   localparam int GL_NUM_ROW_PIXELS = 32;
   localparam int GL_ROW_ADDR_W     = 4;

   typedef struct packed {
      logic [GL_NUM_COL_PIXELS-1:0] red;
      logic [GL_NUM_COL_PIXELS-1:0] green;
      logic [GL_NUM_COL_PIXELS-1:0] blue;
   } rgb_half_t;

   // One panel scan line: top half row and the matching bottom half row.
   typedef struct packed {
      rgb_half_t top;
      rgb_half_t bot;
   } rgb_row_t;

   localparam int GL_RGB_ROW_W = $bits(rgb_row_t);

   typedef struct packed {
      logic                     r1;
      logic                     g1;
      logic                     b1;
      logic                     r2;
      logic                     g2;
      logic                     b2;
      logic                     clk;
      logic                     lat;
      logic                     oe_n;
      logic [GL_ROW_ADDR_W-1:0] addr;
   } hub75_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } row_state_e;

   function automatic int gl_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/led_display_hub_shifter.sv
// Serialises one captured row onto the six HUB75 colour pins, MSB column
// first, with CLK_DIV sys clocks per shift-clock half period.
// Ports: clk_in/reset_in (sync, high), start_in + row_in load a row,
//   hub_*_out colour data and shift clock, done_out in last shift cycle.
module led_display_hub_shifter
   import led_display_row_driver_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic     clk_in,
   input  logic     reset_in,
   input  logic     start_in,
   input  rgb_row_t row_in,
   output logic     hub_r1_out,
   output logic     hub_g1_out,
   output logic     hub_b1_out,
   output logic     hub_r2_out,
   output logic     hub_g2_out,
   output logic     hub_b2_out,
   output logic     hub_clk_out,
   output logic     done_out
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(GL_NUM_COL_PIXELS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(GL_NUM_COL_PIXELS - 1);

   rgb_row_t         row_q;
   logic             busy_q;
   logic             clk_q;
   logic [DIV_W-1:0] div_q;
   logic [BIT_W-1:0] bit_q;
   logic             phase_end;

   assign phase_end = busy_q && (div_q == DIV_LAST);

   // The column index only moves at the end of a high phase, so the
   // pins change together with the falling shift-clock edge.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         row_q  <= '0;
         busy_q <= 1'b0;
         clk_q  <= 1'b0;
         div_q  <= '0;
         bit_q  <= '0;
      end else if (start_in) begin
         row_q  <= row_in;
         busy_q <= 1'b1;
         clk_q  <= 1'b0;
         div_q  <= '0;
         bit_q  <= BIT_LAST;
      end else if (busy_q) begin
         if (phase_end) begin
            div_q <= '0;
            clk_q <= !clk_q;
            if (clk_q) begin
               if (bit_q == '0) begin
                  busy_q <= 1'b0;
               end else begin
                  bit_q <= bit_q - 1'b1;
               end
            end
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

   assign done_out    = phase_end && clk_q && (bit_q == '0);
   assign hub_clk_out = clk_q;
   assign hub_r1_out  = row_q.top.red[bit_q];
   assign hub_g1_out  = row_q.top.green[bit_q];
   assign hub_b1_out  = row_q.top.blue[bit_q];
   assign hub_r2_out  = row_q.bot.red[bit_q];
   assign hub_g2_out  = row_q.bot.green[bit_q];
   assign hub_b2_out  = row_q.bot.blue[bit_q];

endmodule

// File: rtl/led_display_row_driver.sv
// Panel-side row consumer: takes one row per valid/ready handshake and
// drives HUB75 shift/blank/latch/display timing for it.
// Ports: clk_in, reset_in (sync, high); row_in/row_address_in/row_valid_in/
//   row_ready_out handshake; hub_* panel pins; row_done_out end-of-row pulse.
module led_display_row_driver
   import led_display_row_driver_pkg::*;
#(
   parameter int CLK_DIV        = 2,
   parameter int BLANK_CYCLES   = 4,
   parameter int LATCH_CYCLES   = 2,
   parameter int DISPLAY_CYCLES = 256,
   parameter bit SIMULATION     = 1'b0
) (
   input  logic                     clk_in,
   input  logic                     reset_in,
   input  logic [GL_RGB_ROW_W-1:0]  row_in,
   input  logic [GL_ROW_ADDR_W-1:0] row_address_in,
   input  logic                     row_valid_in,
   output logic                     row_ready_out,
   output logic                     hub_r1_out,
   output logic                     hub_g1_out,
   output logic                     hub_b1_out,
   output logic                     hub_r2_out,
   output logic                     hub_g2_out,
   output logic                     hub_b2_out,
   output logic                     hub_clk_out,
   output logic                     hub_lat_out,
   output logic                     hub_oe_n_out,
   output logic [GL_ROW_ADDR_W-1:0] hub_addr_out,
   output logic                     row_done_out
);

   localparam int DISP_EFF = SIMULATION ? 16 : DISPLAY_CYCLES;
   localparam int T_MAX =
      gl_max3(BLANK_CYCLES, LATCH_CYCLES, DISP_EFF);
   localparam int T_W = $clog2(T_MAX + 1);
   localparam logic [T_W-1:0] BLANK_LAST = T_W'(BLANK_CYCLES - 1);
   localparam logic [T_W-1:0] LATCH_LAST = T_W'(LATCH_CYCLES - 1);
   localparam logic [T_W-1:0] DISP_LAST  = T_W'(DISP_EFF - 1);

   generate
      if (CLK_DIV < 1 || BLANK_CYCLES < 1 ||
          LATCH_CYCLES < 1 || DISPLAY_CYCLES < 1) begin : g_bad_cfg
         $error("led_display_row_driver: timing params must be >= 1");
      end
   endgenerate

   row_state_e               state_q;
   row_state_e               state_d;
   logic [T_W-1:0]           tmr_q;
   logic [GL_ROW_ADDR_W-1:0] addr_cap_q;
   logic [GL_ROW_ADDR_W-1:0] addr_pin_q;
   logic                     ready_en_q;
   logic                     take;
   logic                     timed;
   logic                     shift_done;
   hub75_t                   pins;
   logic                     sh_r1, sh_g1, sh_b1;
   logic                     sh_r2, sh_g2, sh_b2;
   logic                     sh_clk;

   assign take  = row_valid_in && row_ready_out;
   assign timed = (state_q == ST_BLANK) || (state_q == ST_LATCH) ||
                  (state_q == ST_DISPLAY);

   led_display_hub_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .start_in    (take),
      .row_in      (rgb_row_t'(row_in)),
      .hub_r1_out  (sh_r1),
      .hub_g1_out  (sh_g1),
      .hub_b1_out  (sh_b1),
      .hub_r2_out  (sh_r2),
      .hub_g2_out  (sh_g2),
      .hub_b2_out  (sh_b2),
      .hub_clk_out (sh_clk),
      .done_out    (shift_done)
   );

   // ready_en_q keeps ready low for the first cycle out of reset.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q    <= ST_IDLE;
         tmr_q      <= '0;
         addr_cap_q <= '0;
         addr_pin_q <= '0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
         if (timed && (state_q == state_d)) begin
            tmr_q <= tmr_q + 1'b1;
         end else begin
            tmr_q <= '0;
         end
         if (take) begin
            addr_cap_q <= row_address_in;
         end
         if (state_q == ST_SHIFT && state_d == ST_BLANK) begin
            addr_pin_q <= addr_cap_q;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (take) state_d = ST_SHIFT;
         ST_SHIFT:   if (shift_done) state_d = ST_BLANK;
         ST_BLANK:   if (tmr_q == BLANK_LAST) state_d = ST_LATCH;
         ST_LATCH:   if (tmr_q == LATCH_LAST) state_d = ST_DISPLAY;
         ST_DISPLAY: if (tmr_q == DISP_LAST) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pins          = '0;
      pins.oe_n     = 1'b1;
      pins.r1       = sh_r1;
      pins.g1       = sh_g1;
      pins.b1       = sh_b1;
      pins.r2       = sh_r2;
      pins.g2       = sh_g2;
      pins.b2       = sh_b2;
      pins.clk      = sh_clk;
      pins.addr     = addr_pin_q;
      row_ready_out = 1'b0;
      row_done_out  = 1'b0;
      unique case (state_q)
         ST_IDLE:  row_ready_out = ready_en_q;
         ST_LATCH: pins.lat = 1'b1;
         ST_DISPLAY: begin
            pins.oe_n    = 1'b0;
            row_done_out = (tmr_q == DISP_LAST);
         end
         default: ;
      endcase
   end

   assign hub_r1_out   = pins.r1;
   assign hub_g1_out   = pins.g1;
   assign hub_b1_out   = pins.b1;
   assign hub_r2_out   = pins.r2;
   assign hub_g2_out   = pins.g2;
   assign hub_b2_out   = pins.b2;
   assign hub_clk_out  = pins.clk;
   assign hub_lat_out  = pins.lat;
   assign hub_oe_n_out = pins.oe_n;
   assign hub_addr_out = pins.addr;

endmodule

// File: tb/tb_led_display_row_driver.sv
// Bench for led_display_row_driver: two instances (normal and short-sim
// timing) checked every cycle against a timeline model of a row.
module tb_led_display_row_driver;
   import led_display_row_driver_pkg::*;

   localparam int NB = 4;
   localparam int NL = 2;

   typedef struct {
      bit       act;
      int       k;
      rgb_row_t row;
      logic [3:0] addr;
      logic [3:0] pin;
      bit       rdy;
   } mdl_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   rgb_row_t   row_a, row_b;
   logic [3:0] adr_a, adr_b;
   logic       vld_a, vld_b;
   logic       rdy_a, r1_a, g1_a, b1_a, r2_a, g2_a, b2_a;
   logic       hclk_a, lat_a, oen_a, done_a;
   logic [3:0] haddr_a;
   logic       rdy_b, r1_b, g1_b, b1_b, r2_b, g2_b, b2_b;
   logic       hclk_b, lat_b, oen_b, done_b;
   logic [3:0] haddr_b;

   led_display_row_driver #(
      .CLK_DIV(2), .BLANK_CYCLES(NB), .LATCH_CYCLES(NL),
      .DISPLAY_CYCLES(256), .SIMULATION(1'b0)
   ) dut_a (
      .clk_in(clk), .reset_in(rst), .row_in(row_a),
      .row_address_in(adr_a), .row_valid_in(vld_a),
      .row_ready_out(rdy_a),
      .hub_r1_out(r1_a), .hub_g1_out(g1_a), .hub_b1_out(b1_a),
      .hub_r2_out(r2_a), .hub_g2_out(g2_a), .hub_b2_out(b2_a),
      .hub_clk_out(hclk_a), .hub_lat_out(lat_a),
      .hub_oe_n_out(oen_a), .hub_addr_out(haddr_a),
      .row_done_out(done_a)
   );

   led_display_row_driver #(
      .CLK_DIV(1), .BLANK_CYCLES(NB), .LATCH_CYCLES(NL),
      .DISPLAY_CYCLES(256), .SIMULATION(1'b1)
   ) dut_b (
      .clk_in(clk), .reset_in(rst), .row_in(row_b),
      .row_address_in(adr_b), .row_valid_in(vld_b),
      .row_ready_out(rdy_b),
      .hub_r1_out(r1_b), .hub_g1_out(g1_b), .hub_b1_out(b1_b),
      .hub_r2_out(r2_b), .hub_g2_out(g2_b), .hub_b2_out(b2_b),
      .hub_clk_out(hclk_b), .hub_lat_out(lat_b),
      .hub_oe_n_out(oen_b), .hub_addr_out(haddr_b),
      .row_done_out(done_b)
   );

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   mdl_t ma, mb;
   int   hs_a, hs_b, hscyc_a;
   int   rises_a, lrise_a, gmin_a, gmax_a, oel_a, dn_a;
   int   rises_b, lrise_b, gmin_b, gmax_b, oel_b, dn_b;
   logic pclk_a, plat_a, pclk_b;
   logic [3:0]  lataddr_a;
   logic [31:0] r1bits, g2bits, b2bits;

   // k = sys cycles since the handshake edge; each row is a fixed
   // timeline of shift (2*c*32), blank, latch and display windows.
   function automatic mdl_t mdl_step(mdl_t m, logic r, logic v,
                                     rgb_row_t rw, logic [3:0] a,
                                     int c, int d);
      int t;
      t = 2 * c * GL_NUM_COL_PIXELS + NB + NL + d;
      if (r) begin
         m.act = 0; m.k = 0; m.row = '0; m.pin = '0; m.rdy = 0;
      end else if (!m.act) begin
         if (m.rdy && v) begin
            m.act = 1; m.k = 0; m.row = rw; m.addr = a; m.rdy = 0;
         end else begin
            m.rdy = 1;
         end
      end else begin
         m.k++;
         if (m.k == 2 * c * GL_NUM_COL_PIXELS) m.pin = m.addr;
         if (m.k == t) begin
            m.act = 0; m.rdy = 1;
         end
      end
      return m;
   endfunction

   function automatic logic [14:0] mdl_exp(mdl_t m, int c, int d);
      int s, idx;
      logic ck, lt, oe, dn;
      s   = 2 * c * GL_NUM_COL_PIXELS;
      idx = 0;
      ck  = 1'b0;
      if (m.act && m.k < s) begin
         idx = GL_NUM_COL_PIXELS - 1 - m.k / (2 * c);
         ck  = (m.k % (2 * c)) >= c;
      end
      lt = m.act && m.k >= s + NB && m.k < s + NB + NL;
      oe = !(m.act && m.k >= s + NB + NL && m.k < s + NB + NL + d);
      dn = m.act && (m.k == s + NB + NL + d - 1);
      return {(!m.act && m.rdy), dn,
              m.row.top.red[idx], m.row.top.green[idx],
              m.row.top.blue[idx], m.row.bot.red[idx],
              m.row.bot.green[idx], m.row.bot.blue[idx],
              ck, lt, oe, m.pin};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      rises_a = 0; lrise_a = 0; gmin_a = 1000; gmax_a = 0;
      oel_a = 0; dn_a = 0; hs_a = 0; lataddr_a = 4'hf;
      rises_b = 0; lrise_b = 0; gmin_b = 1000; gmax_b = 0;
      oel_b = 0; dn_b = 0; hs_b = 0;
      r1bits = '0; g2bits = '0; b2bits = '0;
   endtask

   task automatic step();
      bit pa, pb;
      logic [14:0] act_a, act_b;
      pa = rdy_a && vld_a;
      pb = rdy_b && vld_b;
      @(posedge clk);
      ma = mdl_step(ma, rst, vld_a, row_a, adr_a, 2, 256);
      mb = mdl_step(mb, rst, vld_b, row_b, adr_b, 1, 16);
      if (pa) begin hs_a++; hscyc_a = cyc; end
      if (pb) hs_b++;
      @(negedge clk);
      act_a = {rdy_a, done_a, r1_a, g1_a, b1_a, r2_a, g2_a, b2_a,
               hclk_a, lat_a, oen_a, haddr_a};
      act_b = {rdy_b, done_b, r1_b, g1_b, b1_b, r2_b, g2_b, b2_b,
               hclk_b, lat_b, oen_b, haddr_b};
      chk($sformatf("pins_a@%0d", cyc), 32'(act_a),
          32'(mdl_exp(ma, 2, 256)));
      chk($sformatf("pins_b@%0d", cyc), 32'(act_b),
          32'(mdl_exp(mb, 1, 16)));
      if (hclk_a && !pclk_a) begin
         if (rises_a > 0 && rises_a < 32) begin
            if (cyc - lrise_a < gmin_a) gmin_a = cyc - lrise_a;
            if (cyc - lrise_a > gmax_a) gmax_a = cyc - lrise_a;
         end
         lrise_a = cyc;
         rises_a++;
         r1bits = {r1bits[30:0], r1_a};
         g2bits = {g2bits[30:0], g2_a};
         b2bits = {b2bits[30:0], b2_a};
      end
      if (hclk_b && !pclk_b) begin
         if (rises_b > 0 && rises_b < 32) begin
            if (cyc - lrise_b < gmin_b) gmin_b = cyc - lrise_b;
            if (cyc - lrise_b > gmax_b) gmax_b = cyc - lrise_b;
         end
         lrise_b = cyc;
         rises_b++;
      end
      if (lat_a && !plat_a) lataddr_a = haddr_a;
      pclk_a = hclk_a; pclk_b = hclk_b; plat_a = lat_a;
      if (!oen_a) oel_a++;
      if (done_a) dn_a++;
      if (!oen_b) oel_b++;
      if (done_b) dn_b++;
      cyc++;
   endtask

   task automatic send_a(input rgb_row_t r, input logic [3:0] a);
      int n;
      int h;
      row_a = r; adr_a = a; vld_a = 1'b1;
      n = 0;
      h = hs_a;
      while (hs_a == h && n < 20) begin step(); n++; end
      chk("handshake_a", 32'(hs_a - h), 1);
      vld_a = 1'b0;
   endtask

   task automatic wait_ready_a(input int lim);
      int n;
      n = 0;
      while (!rdy_a && n < lim) begin step(); n++; end
      chk("ready_a_wait", 32'(rdy_a), 1);
   endtask

   initial begin
      rgb_row_t r;
      int n;
      int h;
      rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0;
      row_a = '0; row_b = '0; adr_a = '0; adr_b = '0;
      ma.act = 0; ma.k = 0; ma.row = '0; ma.addr = '0;
      ma.pin = '0; ma.rdy = 0;
      mb = ma;
      pclk_a = 0; pclk_b = 0; plat_a = 0; hscyc_a = 0;
      clr();
      repeat (3) step();
      chk("rst_ready", 32'(rdy_a), 0);
      chk("rst_oen", 32'(oen_a), 1);
      rst = 1'b0;
      step();
      chk("ready_after_release", 32'(rdy_a), 1);

      clr();
      r = '0;
      r.top.red = 32'h8000_0001;
      send_a(r, 4'd5);
      wait_ready_a(600);
      chk("row_period", 32'(cyc - hscyc_a), 391);
      chk("rises", 32'(rises_a), 32);
      chk("gap_min", 32'(gmin_a), 4);
      chk("gap_max", 32'(gmax_a), 4);
      chk("r1_at_rises", r1bits, 32'h8000_0001);
      chk("addr_at_latch", 32'(lataddr_a), 5);
      chk("oe_low_cycles", 32'(oel_a), 256);
      chk("done_pulses", 32'(dn_a), 1);

      clr();
      r = '0;
      r.bot.green = '1;
      r.bot.blue  = 32'h5555_5555;
      send_a(r, 4'd9);
      wait_ready_a(600);
      chk("g2_bits", g2bits, 32'hffff_ffff);
      chk("b2_bits", b2bits, 32'h5555_5555);
      chk("r1_quiet", r1bits, 32'h0);
      chk("addr_at_latch2", 32'(lataddr_a), 9);

      clr();
      r = {$urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom()};
      send_a(r, 4'd3);
      n = 0;
      while (rises_a < 10 && n < 200) begin step(); n++; end
      rst = 1'b1;
      step();
      chk("abort_oen", 32'(oen_a), 1);
      chk("abort_lat", 32'(lat_a), 0);
      chk("abort_clk", 32'(hclk_a), 0);
      chk("abort_ready", 32'(rdy_a), 0);
      rst = 1'b0;
      step();
      chk("abort_ready_back", 32'(rdy_a), 1);

      clr();
      vld_a = 1'b1;
      for (int i = 0; i < 3 * 391; i++) begin
         row_a = {$urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom()};
         adr_a = 4'($urandom());
         step();
      end
      vld_a = 1'b0;
      chk("held_valid_xfers", 32'(hs_a), 3);
      chk("held_valid_done", 32'(dn_a), 3);
      wait_ready_a(600);

      clr();
      for (int a = 0; a < 16; a++) begin
         row_b = {$urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom()};
         adr_b = 4'(a);
         vld_b = 1'b1;
         n = 0;
         h = hs_b;
         while (hs_b == h && n < 200) begin step(); n++; end
      end
      vld_b = 1'b0;
      n = 0;
      while (!rdy_b && n < 200) begin step(); n++; end
      chk("ready_b_wait", 32'(rdy_b), 1);
      chk("b_xfers", 32'(hs_b), 16);
      chk("b_done", 32'(dn_b), 16);
      chk("b_oe_low", 32'(oel_b), 256);
      chk("b_rises", 32'(rises_b), 512);
      chk("b_gap_min", 32'(gmin_b), 2);
      chk("b_gap_max", 32'(gmax_b), 2);
      chk("b_last_addr", 32'(haddr_b), 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
